// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-requester arbiter for a single shared memory bus.
//   m0 is the CPU memory stage and m1 is a DMA/video master. Arbitration is
//   combinational within the cycle. The granted requester drives the bus in
//   the same cycle. Read data comes back one cycle later and is steered to
//   the requester that issued the read.
//
//   m1 can hold m1_lock to keep the bus for back-to-back grants. A burst
//   counter limits this to MAX_BURST grants in a row, so the CPU cannot be
//   starved.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : unlocked contention goes to the requester that was not
//                 granted most recently (an IDLE history counts as m1).
//     undefined : unlocked contention always goes to m0 (fixed CPU priority).
//
//   reset is asynchronous and active-low. While it is low, every grant, bus
//   strobe and read-return output is forced to 0.
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wr_data,
    input  logic        m0_wr_en,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wr_data,
    input  logic        m1_wr_en,
    input  logic        m1_lock,

    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_stall,

    output logic [31:0] m0_rd_data,
    output logic        m0_rd_valid,
    output logic [31:0] m1_rd_data,
    output logic        m1_rd_valid,

    output logic [31:0] bus_addr,
    output logic [31:0] bus_wr_data,
    output logic        bus_wr_en,
    output logic        bus_rd_en,
    input  logic [31:0] bus_rd_data
);

    // Burst limit in the width of the counter. The legal range is 1..15.
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    // Ownership history: which requester held the bus in the previous cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  burst_reg;
    logic [3:0]  burst_next;

    // Read return tracking: one read can be in flight per cycle.
    logic        rd_valid_reg;
    logic        rd_valid_next;
    logic        rd_owner_reg;     // 0 = m0, 1 = m1
    logic        rd_owner_next;

    logic        gnt0;
    logic        gnt1;
    logic        lock_active;

    // Per-requester return vectors, filled by the generate loop below.
    logic [1:0]  ret_valid;
    logic [31:0] ret_data [2];

    // m1 keeps the bus while it holds a lock and has not used up its burst.
    assign lock_active = (state_reg == OWN1) && m1_req && m1_lock &&
                         (burst_reg < BURST_LIMIT);

    // State register, burst counter and read-return flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            burst_reg    <= 4'd0;
            rd_valid_reg <= 1'b0;
            rd_owner_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            burst_reg    <= burst_next;
            rd_valid_reg <= rd_valid_next;
            rd_owner_reg <= rd_owner_next;
        end
    end

    // Grant selection. Grants are suppressed while reset is held low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (lock_active) begin
            gnt1 = 1'b1;
        end else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Alternate: whoever did not own the bus last cycle goes first.
            if (state_reg == OWN0) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
`else
            gnt0 = 1'b1;
`endif
        end else if (m0_req) begin
            gnt0 = 1'b1;
        end else if (m1_req) begin
            gnt1 = 1'b1;
        end
    end

    // Next ownership state and burst count, both driven by this cycle's grant.
    always_comb begin
        state_next = IDLE;
        burst_next = 4'd0;
        if (gnt1) begin
            state_next = OWN1;
            if (state_reg != OWN1) begin
                burst_next = 4'd1;
            end else if (burst_reg < BURST_LIMIT) begin
                burst_next = burst_reg + 4'd1;
            end else begin
                burst_next = burst_reg;
            end
        end else if (gnt0) begin
            state_next = OWN0;
        end
    end

    // Capture a granted read so its data can be steered next cycle.
    always_comb begin
        rd_valid_next = (gnt0 && !m0_wr_en) || (gnt1 && !m1_wr_en);
        rd_owner_next = gnt1;
    end

    // Shared bus mux. The bus is all zeros when nobody is granted.
    always_comb begin
        bus_addr    = 32'd0;
        bus_wr_data = 32'd0;
        bus_wr_en   = 1'b0;
        bus_rd_en   = 1'b0;
        if (gnt0) begin
            bus_addr    = m0_addr;
            bus_wr_data = m0_wr_data;
            bus_wr_en   = m0_wr_en;
            bus_rd_en   = !m0_wr_en;
        end else if (gnt1) begin
            bus_addr    = m1_addr;
            bus_wr_data = m1_wr_data;
            bus_wr_en   = m1_wr_en;
            bus_rd_en   = !m1_wr_en;
        end
    end

    // Read return steering. Only the owner of the in-flight read sees data.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign ret_valid[gi] = rd_valid_reg && (rd_owner_reg == 1'(gi));
            assign ret_data[gi]  = ret_valid[gi] ? bus_rd_data : 32'd0;
        end
    endgenerate

    assign m0_gnt      = gnt0;
    assign m1_gnt      = gnt1;
    assign m0_stall    = m0_req && !gnt0;
    assign m0_rd_valid = ret_valid[0];
    assign m0_rd_data  = ret_data[0];
    assign m1_rd_valid = ret_valid[1];
    assign m1_rd_data  = ret_data[1];

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum number of consecutive grants to m1 while m1_lock is held (range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately, and release is sampled on clk.
REQ-004 m0_req / m1_req  input  1  requester 0 (CPU memory stage) / requester 1 (DMA/video) access request.
REQ-005 m0_addr / m1_addr  input  32  byte address of request.
REQ-006 m0_wr_data / m1_wr_data  input  32  store data.
REQ-007 m0_wr_en / m1_wr_en  input  1  1 = write, 0 = read.
REQ-008 m1_lock  input  1  m1 requests back-to-back ownership (burst).
REQ-009 m0_gnt / m1_gnt  output  1  request accepted this cycle.
REQ-010 m0_stall  output  1  equals m0_req & ~m0_gnt; holds the CPU pipeline.
REQ-011 m0_rd_data / m1_rd_data  output  32  read return data.
REQ-012 m0_rd_valid / m1_rd_valid  output  1  read data valid, one-cycle pulse.
REQ-013 bus_addr  output  32  shared memory bus address.
REQ-014 bus_wr_data  output  32  shared bus store data.
REQ-015 bus_wr_en  output  1  shared bus write strobe.
REQ-016 bus_rd_en  output  1  shared bus read strobe.
REQ-017 bus_rd_data  input  32  memory read data, valid exactly one cycle after bus_rd_en.

Function
REQ-018 Arbitration SHALL be combinational within the cycle; at most one of m0_gnt and m1_gnt SHALL be 1 in any cycle.
REQ-019 A grant SHALL be issued only to an asserted req; if exactly one req is asserted, that requester SHALL be granted.
REQ-020 The granted requester's addr/wr_data/wr_en SHALL drive the bus in the same cycle: bus_wr_en = wr_en, bus_rd_en = ~wr_en; with no grant, bus_wr_en = bus_rd_en = 0 and bus_addr/bus_wr_data = 0.
REQ-021 FSM states: IDLE (no owner last cycle), OWN0 (m0 granted last cycle), OWN1 (m1 granted last cycle); the next state is set by the current grant (m0_gnt -> OWN0, m1_gnt -> OWN1, none -> IDLE).
REQ-022 4-bit burst counter: on entering OWN1 from a non-OWN1 state it SHALL load 1; on each further m1 grant it SHALL increment, saturating at MAX_BURST; it SHALL clear on any non-m1 grant cycle.
REQ-023 Lock rule: in OWN1 with m1_req & m1_lock and count < MAX_BURST, m1 SHALL be granted even if m0_req is asserted; at count == MAX_BURST, m0_req SHALL win that cycle.
REQ-024 Contention without an active lock SHALL be resolved per the Configuration section.
REQ-025 Read return: a 1-bit read-owner register plus a valid flag SHALL capture the granted read; next cycle the owner's rd_valid = 1 and rd_data = bus_rd_data; the other requester's rd_valid = 0 and rd_data = 0.
REQ-026 Write grants SHALL produce no rd_valid pulse.
REQ-027 Back-to-back reads by either requester SHALL each return in order, one cycle latency, with no bubbles.
REQ-028 Dropping req without a grant SHALL be legal and leave no pending state.

Reset
REQ-029 While reset = 0: state = IDLE, burst counter = 0, and read-valid flag = 0; all grants, rd_valid, rd_data, bus strobes, bus_addr and bus_wr_data SHALL be 0.
REQ-030 Reset mid-burst or with a read in flight SHALL discard it, and no rd_valid SHALL pulse in the first cycle after release.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN: when defined, unlocked contention SHALL grant the requester not granted most recently (IDLE treated as m1 last, so m0 wins); when undefined, unlocked contention SHALL always grant m0 (fixed CPU priority).

Verification
REQ-032 Only m0_req=1, read, addr=0x100; bus_rd_data=0xDEADBEEF next cycle -> m0_gnt=1, bus_rd_en=1, bus_addr=0x100; next cycle m0_rd_valid=1, m0_rd_data=0xDEADBEEF.
REQ-033 Both req held 4 cycles, no lock -> fixed build: m0 granted 4x and m1_gnt never; RR build: grants m0,m1,m0,m1 with m0_stall=0,1,0,1.
REQ-034 MAX_BURST=4, m1 holds req+lock for 6 cycles, m0_req=1 from cycle 1 -> m1 granted cycles 0-3, m0 granted cycle 4.
REQ-035 m1 write addr=0x40 data=0x12345678 -> bus_wr_en=1, bus_addr=0x40, bus_wr_data=0x12345678 that cycle; no rd_valid next cycle.
REQ-036 Reset asserted in cycle after m1 read grant -> outputs 0 immediately; m1_rd_valid stays 0 after release.
REQ-037 Alternating m0/m1 reads every cycle -> rd_valid pulses alternate owners, each with correct data one cycle after its grant.
